// File: rtl/adder_response_checker.sv
// adder_response_checker
// Feeds on vector/response pairs from an external adder, compares {cout,s}
// against a+b+cin and keeps per-run vector and mismatch counts.
// Optional build macro: CHECKER_FIRST_FAIL_CAPTURE_EN adds capture of the
// first mismatching pair of a run on the fail_* outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start, no vectors accepted
// ST_RUN  | accepting vector/response pairs, stalls while vec_valid=0
// ST_DONE | NUM_VECS pairs seen, results held until the next start
module adder_response_checker #(
    parameter int WIDTH    = 4,
    parameter int NUM_VECS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_count,
    output logic [15:0]      err_count
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    ,
    output logic             fail_seen,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [WIDTH-1:0] fail_s,
    output logic             fail_cout
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_VEC = 16'(NUM_VECS);

    state_t      state_q, state_d;
    logic [15:0] vec_count_q, vec_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic [WIDTH:0] exp_sum;
    logic        mismatch;

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    logic             fail_seen_q, fail_seen_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic             fail_cin_q, fail_cin_d;
    logic [WIDTH-1:0] fail_s_q, fail_s_d;
    logic             fail_cout_q, fail_cout_d;
`endif

    // Reference sum carried at WIDTH+1 bits so the carry-out is compared too.
    assign exp_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign mismatch = ({cout, s} != exp_sum);

    // Next-state, counter and capture update.
    always_comb begin
        state_d     = state_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
        fail_seen_d = fail_seen_q;
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        fail_cin_d  = fail_cin_q;
        fail_s_d    = fail_s_q;
        fail_cout_d = fail_cout_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // vec_valid is deliberately ignored here, even alongside start.
                if (start) begin
                    state_d     = ST_RUN;
                    vec_count_d = 16'd0;
                    err_count_d = 16'd0;
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
                    fail_seen_d = 1'b0;
                    fail_a_d    = '0;
                    fail_b_d    = '0;
                    fail_cin_d  = 1'b0;
                    fail_s_d    = '0;
                    fail_cout_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (vec_valid) begin
                    vec_count_d = vec_count_q + 16'd1;
                    if (mismatch && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
                    if (mismatch && !fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        fail_a_d    = a;
                        fail_b_d    = b;
                        fail_cin_d  = cin;
                        fail_s_d    = s;
                        fail_cout_d = cout;
                    end
`endif
                    if ((vec_count_q + 16'd1) == LAST_VEC) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers; reset returns everything to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_count_q <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
        end
    end

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    // First-failure capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen_q <= 1'b0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_cin_q  <= 1'b0;
            fail_s_q    <= '0;
            fail_cout_q <= 1'b0;
        end else begin
            fail_seen_q <= fail_seen_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_cin_q  <= fail_cin_d;
            fail_s_q    <= fail_s_d;
            fail_cout_q <= fail_cout_d;
        end
    end

    assign fail_seen = fail_seen_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_cin  = fail_cin_q;
    assign fail_s    = fail_s_q;
    assign fail_cout = fail_cout_q;
`endif

    assign vec_ready = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = (state_q == ST_DONE) && (err_count_q == 16'd0);
    assign vec_count = vec_count_q;
    assign err_count = err_count_q;

endmodule

// File: doc/adder_response_checker.md
ADDER_RESPONSE_CHECKER -- requirements
Module: adder_response_checker

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the adder under check.
REQ-002 Parameter NUM_VECS, default 8: vectors per run, range 1..65535.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, as these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin run; clears counters
- vec_valid  in  1  vector/response pair present
- vec_ready  out  1  checker accepts pair this cycle
- a  in  WIDTH  operand A applied to adder
- b  in  WIDTH  operand B applied to adder
- cin  in  1  carry-in applied to adder
- s  in  WIDTH  adder sum response
- cout  in  1  adder carry-out response
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  high in DONE when err_count==0
- vec_count  out  16  vectors accepted this run
- err_count  out  16  mismatches this run, saturating

Function
REQ-004 FSM states SHALL be IDLE, RUN and DONE, encoded as registered state with no other reachable states.
REQ-005 IDLE: vec_ready=0; start=1 SHALL move to RUN and clear vec_count and err_count at the same edge.
REQ-006 RUN: vec_ready=1 and busy=1; a pair is accepted on each rising edge with vec_valid=1 and vec_ready=1.
REQ-007 Expected value SHALL be a+b+cin computed at WIDTH+1 bits; mismatch when {cout,s} differs from it.
REQ-008 On accept, vec_count SHALL increment and err_count SHALL increment on mismatch, both visible the cycle after the accept (latency 1).
REQ-009 err_count SHALL saturate at 16'hFFFF; vec_count never exceeds NUM_VECS.
REQ-010 The edge accepting vector number NUM_VECS SHALL move to DONE; vec_ready SHALL be 0 from the next cycle.
REQ-011 DONE: done=1, pass=(err_count==0), counters held; start=1 SHALL return to RUN with counters cleared.
REQ-012 start in RUN SHALL be ignored; vec_valid in IDLE or DONE SHALL be ignored, including when it coincides with start.
REQ-013 vec_valid=0 in RUN SHALL stall with all state held, with no timeout.

Reset
REQ-014 rst_n=0 SHALL immediately force IDLE, vec_ready=0, busy=0, done=0, pass=0, vec_count=0, err_count=0, including mid-run.
REQ-015 After rst_n deasserts, the block SHALL stay in IDLE until start=1 is sampled.

Configuration
REQ-016 Macro CHECKER_FIRST_FAIL_CAPTURE_EN SHALL, when defined, add the following outputs: fail_seen (1 bit), fail_a (WIDTH bits), fail_b (WIDTH bits), fail_cin (1 bit), fail_s (WIDTH bits) and fail_cout (1 bit).
REQ-017 With the macro defined, these outputs SHALL latch the first mismatching pair of a run and hold it. They SHALL be cleared by reset or start, with the same one-cycle latency as err_count.
REQ-018 With the macro undefined, these ports and registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-019 Use WIDTH=1 and NUM_VECS=8. Apply start, then all 8 (a,b,cin) combinations with correct {cout,s} -> done=1, pass=1, vec_count=8, err_count=0.
REQ-020 Use WIDTH=1 and NUM_VECS=8. Apply 8 vectors, where vector 3 (a=0,b=1,cin=1) returns s=1,cout=0 -> err_count=1, pass=0. With the macro defined: fail_a=0, fail_b=1, fail_cin=1.
REQ-021 Use WIDTH=4. Apply a=4'hF, b=4'hF, cin=1 with response s=4'hF, cout=1 -> no error. With response cout=0 -> err_count increments one cycle after the accept.
REQ-022 Hold vec_valid low for 5 cycles mid-run -> vec_count unchanged and state remains RUN.
REQ-023 Pulse rst_n low after 3 vectors -> all outputs are 0 immediately. Then apply start and 8 vectors -> vec_count=8.
REQ-024 Assert start in RUN, and vec_valid together with start in IDLE -> start in RUN is ignored, the IDLE vector is not counted, and vec_count after the first RUN cycle is 0.
